// File: rtl/div_issue_if.sv
// Execute-stage request/response and divider handshake bundle for div_issue.
// master = div_issue itself; slave = the execute stage and divider around it.
interface div_issue_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned OPW  = 3;

    logic            req_valid;
    logic            req_ready;
    logic [OPW-1:0]  req_op;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            flush;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;

    logic            div_valid;
    logic [XLEN-1:0] div_srca;
    logic [XLEN-1:0] div_srcb;
    logic            div_data_ok;
    logic [XLEN-1:0] div_result;
    logic [XLEN-1:0] div_rem;

    modport master (
        input  req_valid, req_op, req_src1, req_src2, flush,
        output req_ready, resp_valid, resp_data,
        output div_valid, div_srca, div_srcb,
        input  div_data_ok, div_result, div_rem
    );

    modport slave (
        output req_valid, req_op, req_src1, req_src2, flush,
        input  req_ready, resp_valid, resp_data,
        input  div_valid, div_srca, div_srcb,
        output div_data_ok, div_result, div_rem
    );
endinterface

// File: rtl/div_issue.sv
// RV64M DIV/REM front-end: reduces requests to unsigned operands for the iterative
// divider, resolves divide-by-zero and signed overflow locally, applies sign/word fix-up.
module div_issue (
    input  logic        clk,
    input  logic        resetn,
    div_issue_if.master bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIX, RESP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] srca_q, srca_d, srcb_q, srcb_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic            word_q, word_d, is_rem_q, is_rem_d;
    logic            div_valid_q, div_valid_d;
    logic            resp_valid_q, resp_valid_d;
    logic            req_ready_q, req_ready_d;

    logic            op_word, op_rem, op_uns;
    logic [XLEN-1:0] opa, opb, mag_a, mag_b;
    logic            sign_a, sign_b, div_zero, ovf, special;
    logic [XLEN-1:0] spec_sel, spec_res;
    logic [XLEN-1:0] fix_q, fix_r, fix_sel, fix_res;

    function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] word_zext(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
    endfunction

    // Request decode: operand widening, magnitudes and the locally-resolved cases
    always_comb begin
        op_word = bus.req_op[2];
        op_rem  = bus.req_op[1];
        op_uns  = bus.req_op[0];

        if (op_word) begin
            opa = op_uns ? word_zext(bus.req_src1) : word_sext(bus.req_src1);
            opb = op_uns ? word_zext(bus.req_src2) : word_sext(bus.req_src2);
        end else begin
            opa = bus.req_src1;
            opb = bus.req_src2;
        end

        sign_a = !op_uns && opa[XLEN-1];
        sign_b = !op_uns && opb[XLEN-1];
        mag_a  = sign_a ? XLEN'(-opa) : opa;
        mag_b  = sign_b ? XLEN'(-opb) : opb;

        div_zero = (opb == '0);
        ovf      = !op_uns && (opa == (op_word ? MIN_W : MIN_D)) && (opb == '1);
        special  = div_zero || ovf;

        if (op_rem) spec_sel = div_zero ? opa : '0;
        else        spec_sel = div_zero ? '1  : opa;
        spec_res = op_word ? word_sext(spec_sel) : spec_sel;
    end

    // Sign and word fix-up of the latched divider results
    always_comb begin
        fix_q   = neg_quo_q ? XLEN'(-quo_q) : quo_q;
        fix_r   = neg_rem_q ? XLEN'(-rem_q) : rem_q;
        fix_sel = is_rem_q ? fix_r : fix_q;
        fix_res = word_q ? word_sext(fix_sel) : fix_sel;
    end

    always_comb begin
        state_d     = state_q;
        srca_d      = srca_q;
        srcb_d      = srcb_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        resp_data_d = resp_data_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        word_d      = word_q;
        is_rem_d    = is_rem_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    srca_d    = mag_a;
                    srcb_d    = mag_b;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    word_d    = op_word;
                    is_rem_d  = op_rem;
                    if (special) begin
                        resp_data_d = spec_res;
                        state_d     = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.div_data_ok) begin
                    quo_d   = bus.div_result;
                    rem_d   = bus.div_rem;
                    state_d = FIX;
                end
            end
            FIX: begin
                resp_data_d = fix_res;
                state_d     = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.flush) state_d = IDLE;

        // Handshake outputs are registered copies of the next-state decode
        div_valid_d  = (state_d == BUSY);
        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            srca_q       <= '0;
            srcb_q       <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            resp_data_q  <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            word_q       <= 1'b0;
            is_rem_q     <= 1'b0;
            div_valid_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            resp_data_q  <= resp_data_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            word_q       <= word_d;
            is_rem_q     <= is_rem_d;
            div_valid_q  <= div_valid_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    // A flush in the response cycle swallows the pulse
    assign bus.resp_valid = resp_valid_q && !bus.flush;
    assign bus.resp_data  = resp_data_q;
    assign bus.div_valid  = div_valid_q;
    assign bus.div_srca   = srca_q;
    assign bus.div_srcb   = srcb_q;
endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a fixed-latency unsigned divider model.
module tb_div_issue;
    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_REM   = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVW  = 3'b100;
    localparam logic [2:0] OP_DIVUW = 3'b101;
    localparam logic [2:0] OP_REMW  = 3'b110;

    logic        clk = 1'b0;
    logic        resetn;
    int          checks = 0;
    int          errors = 0;
    int          m_lat;
    int          m_cnt;
    logic        m_done;
    logic        model_ok;
    logic        stray_ok;
    logic [63:0] m_quo, m_rem;

    div_issue_if bus ();

    div_issue dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.div_data_ok = model_ok | stray_ok;
    assign bus.div_result  = m_quo;
    assign bus.div_rem     = m_rem;

    // Divider model: answers m_lat cycles after div_valid rises, once per request
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt    <= 0;
            m_done   <= 1'b0;
            model_ok <= 1'b0;
            m_quo    <= '0;
            m_rem    <= '0;
        end else begin
            model_ok <= 1'b0;
            if (!bus.div_valid) begin
                m_cnt  <= 0;
                m_done <= 1'b0;
            end else if (!m_done) begin
                if (m_cnt == m_lat - 1) begin
                    model_ok <= 1'b1;
                    m_done   <= 1'b1;
                    m_quo    <= bus.div_srca / bus.div_srcb;
                    m_rem    <= bus.div_srca % bus.div_srcb;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response
    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] s1,
                          input logic [63:0] s2, input logic [63:0] expd, input logic spcl,
                          input logic [63:0] ea, input logic [63:0] eb);
        int   cyc;
        int   ok_at;
        logic got;
        logic saw_dv;
        check({tag, ":ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = s1;
        bus.req_src2  = s2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (!spcl) begin
            check({tag, ":div_valid"}, 64'(bus.div_valid), 64'd1);
            check({tag, ":srca"}, bus.div_srca, ea);
            check({tag, ":srcb"}, bus.div_srcb, eb);
        end
        cyc    = 1;
        ok_at  = -1;
        got    = 1'b0;
        saw_dv = 1'b0;
        while (!got && cyc < 300) begin
            if (bus.div_valid) saw_dv = 1'b1;
            if (bus.div_data_ok && ok_at < 0) ok_at = cyc;
            if (bus.resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, ":resp_seen"}, 64'(got), 64'd1);
        check({tag, ":data"}, bus.resp_data, expd);
        if (spcl) begin
            check({tag, ":latency"}, 64'(cyc), 64'd1);
            check({tag, ":no_div_valid"}, 64'(saw_dv), 64'd0);
        end else begin
            check({tag, ":latency"}, 64'(cyc), 64'(ok_at + 2));
        end
        @(negedge clk);
        check({tag, ":pulse_end"}, 64'(bus.resp_valid), 64'd0);
        check({tag, ":ready_after"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, ":resp_data"}, bus.resp_data, 64'd0);
        check({tag, ":div_valid"}, 64'(bus.div_valid), 64'd0);
        check({tag, ":srca"}, bus.div_srca, 64'd0);
        check({tag, ":srcb"}, bus.div_srcb, 64'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.flush     = 1'b0;
        stray_ok      = 1'b0;
        m_lat         = 5;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        resetn = 1'b1;
        @(negedge clk);
        check("reset:ready", 64'(bus.req_ready), 64'd1);

        m_lat = 65;
        run_op("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 1'b0, 64'd100, 64'd7);
        run_op("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 1'b0, 64'd100, 64'd7);
        m_lat = 5;
        run_op("div_m7_2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'd7, 64'd2);
        run_op("rem_m7_2", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd7, 64'd2);
        run_op("rem_7_m2", OP_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 64'd7, 64'd2);
        run_op("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 64'd0, 64'd0);
        run_op("remw_ovf", OP_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 64'd0);
        run_op("div_ovf64", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 64'd0);
        run_op("divu_by0", OP_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 64'd0);
        run_op("remu_by0", OP_REMU, 64'h1234, 64'd0, 64'h1234, 1'b1, 64'd0, 64'd0);
        run_op("remw_by0", OP_REMW, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1, 64'd0, 64'd0);
        run_op("divuw", OP_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0002, 64'h0000_0000_7FFF_FFFF, 1'b0, 64'hFFFF_FFFE, 64'd2);

        // Flush on the 20th BUSY cycle, then an immediate new request
        m_lat         = 1000;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_src1  = 64'd100;
        bus.req_src2  = 64'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("flush_busy:pre", 64'(bus.div_valid), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy:div_valid", 64'(bus.div_valid), 64'd0);
        check("flush_busy:resp_valid", 64'(bus.resp_valid), 64'd0);
        check("flush_busy:ready", 64'(bus.req_ready), 64'd1);
        m_lat = 5;
        run_op("divu_after_flush", OP_DIVU, 64'd9, 64'd3, 64'd3, 1'b0, 64'd9, 64'd3);

        // Request presented together with flush is dropped
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_src1  = 64'd100;
        bus.req_src2  = 64'd7;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_req:div_valid", 64'(bus.div_valid), 64'd0);
        check("flush_req:ready", 64'(bus.req_ready), 64'd1);

        // Flush in the response cycle suppresses the pulse
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_src1  = 64'h1234;
        bus.req_src2  = 64'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("flush_resp:pre", 64'(bus.resp_valid), 64'd1);
        bus.flush = 1'b1;
        #1;
        check("flush_resp:suppressed", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_resp:after", 64'(bus.resp_valid), 64'd0);
        check("flush_resp:ready", 64'(bus.req_ready), 64'd1);

        // Stray completion while idle
        stray_ok = 1'b1;
        @(negedge clk);
        stray_ok = 1'b0;
        check("stray:div_valid", 64'(bus.div_valid), 64'd0);
        check("stray:resp_valid", 64'(bus.resp_valid), 64'd0);
        check("stray:ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        check("stray:resp_later", 64'(bus.resp_valid), 64'd0);

        // Reset in the middle of a divide
        m_lat         = 1000;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_src1  = 64'd100;
        bus.req_src2  = 64'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset:pre", 64'(bus.div_valid), 64'd1);
        resetn = 1'b0;
        #1;
        check_reset_vals("midreset");
        check("midreset:ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        m_lat  = 5;
        @(negedge clk);
        run_op("div_after_reset", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'd7, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
